// File: rtl/anim_pkg.sv
// Shared encodings for the multi-region animator: modes, register map, field positions.
package anim_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_STEP  = 2'd1,
        MODE_DIM   = 2'd2,
        MODE_PULSE = 2'd3
    } mode_t;

    typedef enum logic {
        SC_IDLE  = 1'b0,
        SC_SCALE = 1'b1
    } scaler_state_t;

    localparam logic [2:0] REG_BOUNDS = 3'd0;
    localparam logic [2:0] REG_COLOR  = 3'd1;
    localparam logic [2:0] REG_MODE   = 3'd2;
    localparam logic [2:0] REG_STEP   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int STARTCOL_LSB = 24;
    localparam int ENDCOL_LSB   = 16;
    localparam int STARTROW_LSB = 8;
    localparam int ENDROW_LSB   = 0;

    localparam int RED_LSB   = 0;
    localparam int GREEN_LSB = 8;
    localparam int BLUE_LSB  = 16;

    localparam int DIR_BIT = 16;

endpackage

// File: rtl/anim_level_ctrl.sv
// One region's brightness envelope: saturating level update once per frame tick.
// dir: 0 = ramping up, 1 = ramping down (only PULSE changes it).
module anim_level_ctrl
    import anim_pkg::*;
#(
    parameter int LEVEL_BITS = 8
) (
    input  logic                  clock_clk,
    input  logic                  reset_rst,
    input  logic                  tick,
    input  logic                  trig,
    input  mode_t                 mode,
    input  logic [LEVEL_BITS-1:0] step,
    output logic [LEVEL_BITS-1:0] level,
    output logic                  dir
);

    localparam logic [LEVEL_BITS-1:0] LMAX   = '1;
    localparam logic [LEVEL_BITS:0]   LMAX_W = {1'b0, LMAX};

    logic [LEVEL_BITS:0]   lvl_w, stp_w, sum, diff;
    logic [LEVEL_BITS-1:0] inc, dec, level_nxt;
    logic                  dir_nxt;

    // Next level/dir from the current mode, computed one bit wider so clipping is visible.
    always_comb begin
        lvl_w     = {1'b0, level};
        stp_w     = {1'b0, step};
        sum       = lvl_w + stp_w;
        diff      = lvl_w - stp_w;
        inc       = (sum > LMAX_W) ? LMAX : sum[LEVEL_BITS-1:0];
        dec       = (lvl_w > stp_w) ? diff[LEVEL_BITS-1:0] : '0;
        level_nxt = level;
        dir_nxt   = dir;
        case (mode)
            MODE_OFF:  level_nxt = '0;
            MODE_STEP: level_nxt = trig ? LMAX : '0;
            MODE_DIM:  level_nxt = trig ? inc : dec;
            MODE_PULSE: begin
                if (!trig) begin
                    level_nxt = dec;
                    dir_nxt   = 1'b0;
                end else if (!dir) begin
                    level_nxt = inc;
                    if (sum >= LMAX_W) dir_nxt = 1'b1;
                end else begin
                    level_nxt = dec;
                    if (lvl_w <= stp_w) dir_nxt = 1'b0;
                end
            end
        endcase
    end

    // Level/dir state advances only on the frame tick.
    always_ff @(posedge clock_clk or posedge reset_rst) begin
        if (reset_rst) begin
            level <= '0;
            dir   <= 1'b0;
        end else if (tick) begin
            level <= level_nxt;
            dir   <= dir_nxt;
        end
    end

endmodule

// File: rtl/multi_region_animator.sv
// Multi-region animator: register file, v_sync tick, per-frame colour scaler, two pixel lookups.
//
// Scaler FSM
//   state    | meaning
//   SC_IDLE  | waiting for the frame tick
//   SC_SCALE | scaling region sc_idx's shadow colour by its level, one region per cycle
module multi_region_animator
    import anim_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ROW_BITS    = 4,
    parameter int COL_BITS    = 6,
    parameter int COLOR_BITS  = 8,
    parameter int LEVEL_BITS  = 8
) (
    input  logic                               clock_clk,
    input  logic                               reset_rst,
    input  logic                               v_sync,
    input  logic [$clog2(NUM_REGIONS)+2:0]     s0_address,
    input  logic                               s0_read,
    output logic [31:0]                        s0_readdata,
    input  logic                               s0_write,
    input  logic [31:0]                        s0_writedata,
    input  logic [NUM_REGIONS-1:0]             event_trigger,
    input  logic [COL_BITS-1:0]                col1,
    input  logic [ROW_BITS-1:0]                row1,
    input  logic [3:0]                         bitplane1,
    input  logic [COL_BITS-1:0]                col2,
    input  logic [ROW_BITS-1:0]                row2,
    input  logic [3:0]                         bitplane2,
    output logic                               red1,
    output logic                               green1,
    output logic                               blue1,
    output logic                               red2,
    output logic                               green2,
    output logic                               blue2
);

    localparam int AW       = $clog2(NUM_REGIONS) + 3;
    localparam int IDX_BITS = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int PW       = COLOR_BITS + LEVEL_BITS;
    localparam logic [LEVEL_BITS-1:0] LMAX = '1;

    typedef logic [2:0][COLOR_BITS-1:0] rgb_t;   // [0]=R [1]=G [2]=B

    logic [31:0]           bounds_r  [NUM_REGIONS];
    rgb_t                  col_r     [NUM_REGIONS];
    mode_t                 mode_r    [NUM_REGIONS];
    logic [LEVEL_BITS-1:0] step_r    [NUM_REGIONS];
    logic [31:0]           sh_bounds [NUM_REGIONS];
    rgb_t                  sh_col    [NUM_REGIONS];
    rgb_t                  scaled    [NUM_REGIONS];
    logic [LEVEL_BITS-1:0] level     [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] dir;

    logic [AW-1:0]       a_region;
    logic [IDX_BITS-1:0] a_idx;
    logic [2:0]          a_off;
    logic                a_valid;
    logic [31:0]         rd_val;
    logic [2:0]          vs_q;
    logic                tick;

    scaler_state_t         state, state_nxt;
    logic [IDX_BITS-1:0]   sc_idx, sc_idx_nxt;
    logic [LEVEL_BITS-1:0] cur_lvl;
    rgb_t                  cur_col;
    logic [2:0]            px1, px2;

    assign a_region = s0_address >> 3;
    assign a_idx    = a_region[IDX_BITS-1:0];
    assign a_off    = s0_address[2:0];
    assign a_valid  = a_region < AW'(NUM_REGIONS);
    assign tick     = vs_q[1] & ~vs_q[2];

    function automatic logic [COLOR_BITS-1:0] scale(input logic [COLOR_BITS-1:0] c,
                                                   input logic [LEVEL_BITS-1:0] l);
        logic [PW-1:0] p;
        p = PW'(c) * PW'(l);
        return (l == LMAX) ? c : p[PW-1:LEVEL_BITS];
    endfunction

    // Lowest-index region wins: scan downward so the last hit assigned is the lowest.
    function automatic logic [2:0] lookup(input logic [COL_BITS-1:0] c,
                                          input logic [ROW_BITS-1:0] rw,
                                          input logic [3:0] bp);
        logic [2:0] px;
        logic [7:0] cc, rr;
        px = '0;
        cc = 8'(c);
        rr = 8'(rw);
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (cc >= sh_bounds[r][STARTCOL_LSB+:8] && cc <= sh_bounds[r][ENDCOL_LSB+:8] &&
                rr >= sh_bounds[r][STARTROW_LSB+:8] && rr <= sh_bounds[r][ENDROW_LSB+:8]) begin
                for (int k = 0; k < 3; k++)
                    px[k] = |(scaled[r][k] & (COLOR_BITS'(1) << bp));
            end
        end
        return px;
    endfunction

    // Region register writes; out-of-range regions and offsets 4..7 are dropped.
    always_ff @(posedge clock_clk or posedge reset_rst) begin
        if (reset_rst) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                bounds_r[r] <= '0;
                col_r[r]    <= '0;
                mode_r[r]   <= MODE_OFF;
                step_r[r]   <= '0;
            end
        end else if (s0_write && a_valid) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                if (a_idx == IDX_BITS'(r)) begin
                    case (a_off)
                        REG_BOUNDS: bounds_r[r] <= s0_writedata;
                        REG_COLOR:  col_r[r]    <= {COLOR_BITS'(s0_writedata[BLUE_LSB+:8]),
                                                    COLOR_BITS'(s0_writedata[GREEN_LSB+:8]),
                                                    COLOR_BITS'(s0_writedata[RED_LSB+:8])};
                        REG_MODE:   mode_r[r]   <= mode_t'(s0_writedata[1:0]);
                        REG_STEP:   step_r[r]   <= s0_writedata[LEVEL_BITS-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        rd_val = '0;
        if (a_valid) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                if (a_idx == IDX_BITS'(r)) begin
                    case (a_off)
                        REG_BOUNDS: rd_val = bounds_r[r];
                        REG_COLOR:  rd_val = {8'h00, 8'(col_r[r][2]), 8'(col_r[r][1]), 8'(col_r[r][0])};
                        REG_MODE:   rd_val = 32'(mode_r[r]);
                        REG_STEP:   rd_val = 32'(step_r[r]);
                        REG_STATUS: begin
                            rd_val          = 32'(level[r]);
                            rd_val[DIR_BIT] = dir[r];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Registered read data, zero whenever the previous cycle had no read.
    always_ff @(posedge clock_clk or posedge reset_rst) begin
        if (reset_rst) s0_readdata <= '0;
        else           s0_readdata <= s0_read ? rd_val : '0;
    end

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge clock_clk or posedge reset_rst) begin
        if (reset_rst) vs_q <= '0;
        else           vs_q <= {vs_q[1:0], v_sync};
    end

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_level
        anim_level_ctrl #(.LEVEL_BITS(LEVEL_BITS)) u_level (
            .clock_clk (clock_clk),
            .reset_rst (reset_rst),
            .tick      (tick),
            .trig      (event_trigger[g]),
            .mode      (mode_r[g]),
            .step      (step_r[g]),
            .level     (level[g]),
            .dir       (dir[g])
        );
    end

    // Frame shadows: pixels only see bounds/colour latched at the last tick.
    always_ff @(posedge clock_clk or posedge reset_rst) begin
        if (reset_rst) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                sh_bounds[r] <= '0;
                sh_col[r]    <= '0;
            end
        end else if (tick) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                sh_bounds[r] <= bounds_r[r];
                sh_col[r]    <= col_r[r];
            end
        end
    end

    // Scaler state register.
    always_ff @(posedge clock_clk or posedge reset_rst) begin
        if (reset_rst) begin
            state  <= SC_IDLE;
            sc_idx <= '0;
        end else begin
            state  <= state_nxt;
            sc_idx <= sc_idx_nxt;
        end
    end

    // Scaler next state; ticks arriving mid-scan are not restarted.
    always_comb begin
        state_nxt  = state;
        sc_idx_nxt = sc_idx;
        case (state)
            SC_IDLE: begin
                if (tick) begin
                    state_nxt  = SC_SCALE;
                    sc_idx_nxt = '0;
                end
            end
            SC_SCALE: begin
                if (sc_idx == IDX_BITS'(NUM_REGIONS - 1)) state_nxt = SC_IDLE;
                else                                      sc_idx_nxt = sc_idx + IDX_BITS'(1);
            end
        endcase
    end

    // Select the region currently being scaled.
    always_comb begin
        cur_lvl = '0;
        cur_col = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (sc_idx == IDX_BITS'(r)) begin
                cur_lvl = level[r];
                cur_col = sh_col[r];
            end
        end
    end

    // Store the pre-scaled colour of the selected region.
    always_ff @(posedge clock_clk or posedge reset_rst) begin
        if (reset_rst) begin
            for (int r = 0; r < NUM_REGIONS; r++) scaled[r] <= '0;
        end else if (state == SC_SCALE) begin
            for (int r = 0; r < NUM_REGIONS; r++)
                if (sc_idx == IDX_BITS'(r))
                    for (int k = 0; k < 3; k++) scaled[r][k] <= scale(cur_col[k], cur_lvl);
        end
    end

    // Combinational hit search for both channels.
    always_comb begin
        px1 = lookup(col1, row1, bitplane1);
        px2 = lookup(col2, row2, bitplane2);
    end

    // Registered pixel outputs.
    always_ff @(posedge clock_clk or posedge reset_rst) begin
        if (reset_rst) begin
            {blue1, green1, red1} <= '0;
            {blue2, green2, red2} <= '0;
        end else begin
            {blue1, green1, red1} <= px1;
            {blue2, green2, red2} <= px2;
        end
    end

endmodule

// File: tb/tb_multi_region_animator.sv
// Self-checking bench: directed scenarios plus randomized frames against a behavioural model.
module tb_multi_region_animator;

    localparam int NR = 3;               // 3 regions so that region index 3 is addressable but invalid
    localparam int AW = $clog2(NR) + 3;

    logic            clock_clk = 1'b0;
    logic            reset_rst = 1'b1;
    logic            v_sync = 1'b0;
    logic [AW-1:0]   s0_address = '0;
    logic            s0_read = 1'b0;
    logic [31:0]     s0_readdata;
    logic            s0_write = 1'b0;
    logic [31:0]     s0_writedata = '0;
    logic [NR-1:0]   event_trigger = '0;
    logic [5:0]      col1 = '0, col2 = '0;
    logic [3:0]      row1 = '0, row2 = '0;
    logic [3:0]      bitplane1 = '0, bitplane2 = '0;
    logic            red1, green1, blue1, red2, green2, blue2;

    int passed = 0;
    int total  = 0;

    // behavioural model
    logic [31:0] m_bounds [NR];
    int          m_col    [NR][3];
    int          m_mode   [NR];
    int          m_step   [NR];
    int          m_level  [NR];
    int          m_dir    [NR];
    logic [31:0] m_sh_bounds [NR];
    int          m_sh_col [NR][3];
    int          m_scaled [NR][3];

    multi_region_animator #(.NUM_REGIONS(NR)) dut (
        .clock_clk(clock_clk), .reset_rst(reset_rst), .v_sync(v_sync),
        .s0_address(s0_address), .s0_read(s0_read), .s0_readdata(s0_readdata),
        .s0_write(s0_write), .s0_writedata(s0_writedata), .event_trigger(event_trigger),
        .col1(col1), .row1(row1), .bitplane1(bitplane1),
        .col2(col2), .row2(row2), .bitplane2(bitplane2),
        .red1(red1), .green1(green1), .blue1(blue1),
        .red2(red2), .green2(green2), .blue2(blue2)
    );

    always #5 clock_clk = ~clock_clk;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_bounds[i] = 0; m_sh_bounds[i] = 0;
            m_mode[i] = 0; m_step[i] = 0; m_level[i] = 0; m_dir[i] = 0;
            for (int k = 0; k < 3; k++) begin
                m_col[i][k] = 0; m_sh_col[i][k] = 0; m_scaled[i][k] = 0;
            end
        end
    endtask

    task automatic model_tick();
        for (int i = 0; i < NR; i++) begin
            int l, s;
            bit t;
            l = m_level[i]; s = m_step[i]; t = event_trigger[i];
            case (m_mode[i])
                0: l = 0;
                1: l = t ? 255 : 0;
                2: l = t ? ((l + s > 255) ? 255 : l + s) : ((l - s < 0) ? 0 : l - s);
                default: begin
                    if (!t) begin
                        l = (l - s < 0) ? 0 : l - s;
                        m_dir[i] = 0;
                    end else if (m_dir[i] == 0) begin
                        l = l + s;
                        if (l >= 255) begin l = 255; m_dir[i] = 1; end
                    end else begin
                        l = l - s;
                        if (l <= 0) begin l = 0; m_dir[i] = 0; end
                    end
                end
            endcase
            m_level[i] = l;
            m_sh_bounds[i] = m_bounds[i];
            for (int k = 0; k < 3; k++) begin
                m_sh_col[i][k] = m_col[i][k];
                m_scaled[i][k] = (l == 255) ? m_col[i][k] : (m_col[i][k] * l) / 256;
            end
        end
    endtask

    function automatic logic [2:0] model_px(int c, int r, int bp);
        for (int i = 0; i < NR; i++) begin
            int sc, ec, sr, er;
            sc = int'(m_sh_bounds[i][31:24]); ec = int'(m_sh_bounds[i][23:16]);
            sr = int'(m_sh_bounds[i][15:8]);  er = int'(m_sh_bounds[i][7:0]);
            if (sc <= c && c <= ec && sr <= r && r <= er) begin
                logic [2:0] p;
                if (bp >= 8) return 3'b000;
                for (int k = 0; k < 3; k++) p[k] = ((m_scaled[i][k] >> bp) & 1) != 0;
                return p;
            end
        end
        return 3'b000;
    endfunction

    function automatic logic [31:0] model_status(int i);
        return (32'(m_dir[i]) << 16) | 32'(m_level[i]);
    endfunction

    task automatic wr(input int region, input int off, input logic [31:0] d);
        @(negedge clock_clk);
        s0_address = AW'(region * 8 + off);
        s0_writedata = d;
        s0_write = 1'b1;
        @(negedge clock_clk);
        s0_write = 1'b0;
        if (region < NR) begin
            case (off)
                0: m_bounds[region] = d;
                1: begin m_col[region][0] = int'(d[7:0]); m_col[region][1] = int'(d[15:8]); m_col[region][2] = int'(d[23:16]); end
                2: m_mode[region] = int'(d[1:0]);
                3: m_step[region] = int'(d[7:0]);
                default: ;
            endcase
        end
    endtask

    task automatic rd(input int region, input int off, output logic [31:0] d);
        @(negedge clock_clk);
        s0_address = AW'(region * 8 + off);
        s0_read = 1'b1;
        @(posedge clock_clk);
        #1 d = s0_readdata;
        @(negedge clock_clk);
        s0_read = 1'b0;
    endtask

    task automatic frame();
        @(negedge clock_clk);
        v_sync = 1'b1;
        repeat (NR + 8) @(negedge clock_clk);
        v_sync = 1'b0;
        repeat (4) @(negedge clock_clk);
        model_tick();
    endtask

    task automatic px(input int c1, input int r1, input int b1, input int c2, input int r2, input int b2);
        @(negedge clock_clk);
        col1 = 6'(c1); row1 = 4'(r1); bitplane1 = 4'(b1);
        col2 = 6'(c2); row2 = 4'(r2); bitplane2 = 4'(b2);
        @(posedge clock_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_rst = 1'b1;
        repeat (3) @(negedge clock_clk);
        reset_rst = 1'b0;
        model_reset();
        for (int r = 0; r < 4; r++) begin
            for (int o = 0; o < 8; o++) begin
                rd(r, o, d);
                total++;
                if (d !== 32'h0) $display("FAIL reset_read r%0d o%0d got %h want 0", r, o, d);
                else passed++;
            end
        end
        @(posedge clock_clk);
        #1 total++;
        if (s0_readdata !== 32'h0) $display("FAIL idle_readdata got %h want 0", s0_readdata);
        else passed++;
        total++;
        if ({red1, green1, blue1, red2, green2, blue2} !== 6'b0)
            $display("FAIL reset_pixels got %b want 0", {red1, green1, blue1, red2, green2, blue2});
        else passed++;
    endtask

    task automatic test_dim();
        logic [31:0] d;
        int exp_up [4] = '{64, 128, 192, 255};
        wr(0, 0, 32'h0A140208);
        wr(0, 1, 32'h000000FF);
        wr(0, 2, 32'd2);
        wr(0, 3, 32'd64);
        event_trigger = 3'b001;
        for (int i = 0; i < 4; i++) begin
            frame();
            rd(0, 4, d);
            total++;
            if (d !== 32'(exp_up[i])) $display("FAIL dim_up_%0d got %0d want %0d", i, d, exp_up[i]);
            else passed++;
        end
        px(10, 2, 7, 21, 2, 7);
        total++;
        if ({red1, red2} !== 2'b10) $display("FAIL dim_pixel got r1=%b r2=%b want r1=1 r2=0", red1, red2);
        else passed++;
        event_trigger = 3'b000;
        repeat (4) frame();
        rd(0, 4, d);
        total++;
        if (d !== 32'h0) $display("FAIL dim_down got %0d want 0", d);
        else passed++;
        px(10, 2, 7, 10, 2, 7);
        total++;
        if (red1 !== 1'b0) $display("FAIL dim_dark got %b want 0", red1);
        else passed++;
    endtask

    task automatic test_step();
        logic [31:0] d;
        wr(0, 1, 32'h00000080);
        wr(0, 2, 32'd1);
        event_trigger = 3'b001;
        frame();
        rd(0, 4, d);
        total++;
        if (d[7:0] !== 8'hFF) $display("FAIL step_level got %0d want 255", d[7:0]);
        else passed++;
        px(10, 2, 7, 10, 2, 6);
        total++;
        if ({red1, red2} !== 2'b10) $display("FAIL step_bp7_bp6 got %b%b want 10", red1, red2);
        else passed++;
        px(10, 2, 9, 15, 8, 7);
        total++;
        if ({red1, red2} !== 2'b01) $display("FAIL step_bp9_corner got %b%b want 01", red1, red2);
        else passed++;
    endtask

    task automatic test_pulse();
        logic [31:0] d;
        int exp_l [7] = '{100, 200, 255, 155, 55, 0, 100};
        int exp_d [7] = '{0, 0, 1, 1, 1, 0, 0};
        wr(0, 2, 32'd0);
        frame();
        wr(0, 2, 32'd3);
        wr(0, 3, 32'd100);
        event_trigger = 3'b001;
        for (int i = 0; i < 7; i++) begin
            frame();
            rd(0, 4, d);
            total++;
            if (d !== ((32'(exp_d[i]) << 16) | 32'(exp_l[i])))
                $display("FAIL pulse_%0d got %h want dir=%0d level=%0d", i, d, exp_d[i], exp_l[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] d;
        // level 100, R=0x80 -> scaled 50 = 0b00110010
        px(10, 2, 5, 10, 2, 1);
        total++;
        if ({red1, red2} !== 2'b11) $display("FAIL pre_reset_pixel got %b%b want 11", red1, red2);
        else passed++;
        #2 reset_rst = 1'b1;
        #1 total++;
        if ({red1, green1, blue1, red2, green2, blue2, s0_readdata} !== 38'b0)
            $display("FAIL async_reset got %b want 0", {red1, green1, blue1, red2, green2, blue2});
        else passed++;
        @(negedge clock_clk);
        reset_rst = 1'b0;
        model_reset();
        event_trigger = '0;
        rd(0, 4, d);
        total++;
        if (d !== 32'h0) $display("FAIL reset_status got %h want 0", d);
        else passed++;
    endtask

    task automatic test_overlap_shadow();
        logic [31:0] d;
        wr(0, 0, 32'h000A000A); wr(0, 1, 32'h0000FF); wr(0, 2, 32'd1);
        wr(1, 0, 32'h000A000A); wr(1, 1, 32'h00FF00); wr(1, 2, 32'd1);
        event_trigger = 3'b011;
        frame();
        px(5, 5, 7, 5, 5, 8);
        total++;
        if ({red1, green1, red2, green2} !== 4'b1000)
            $display("FAIL overlap got r1=%b g1=%b r2=%b g2=%b want 1 0 0 0", red1, green1, red2, green2);
        else passed++;
        // disable region 0: off and an empty window
        wr(0, 2, 32'd0); wr(0, 0, 32'h0A000A00);
        frame();
        px(5, 5, 7, 5, 5, 7);
        total++;
        if ({red1, green1} !== 2'b01) $display("FAIL overlap_disabled got r=%b g=%b want 0 1", red1, green1);
        else passed++;
        wr(1, 0, 32'h14200C0F);
        px(5, 5, 7, 25, 13, 7);
        total++;
        if ({green1, green2} !== 2'b10) $display("FAIL shadow_hold got %b%b want 10", green1, green2);
        else passed++;
        frame();
        px(5, 5, 7, 25, 13, 7);
        total++;
        if ({green1, green2} !== 2'b01) $display("FAIL shadow_update got %b%b want 01", green1, green2);
        else passed++;
        wr(2, 0, 32'h100A0000); wr(2, 1, 32'hFF0000); wr(2, 2, 32'd1);
        event_trigger = 3'b111;
        frame();
        px(12, 0, 7, 16, 0, 7);
        total++;
        if ({blue1, blue2} !== 2'b00) $display("FAIL start_gt_end got %b%b want 00", blue1, blue2);
        else passed++;
        wr(3, 0, 32'hFFFFFFFF);
        rd(3, 0, d);
        total++;
        if (d !== 32'h0) $display("FAIL bad_region_read got %h want 0", d);
        else passed++;
        rd(0, 0, d);
        total++;
        if (d !== 32'h0A000A00) $display("FAIL bad_region_alias got %h want 0a000a00", d);
        else passed++;
        wr(0, 5, 32'hFFFFFFFF);
        rd(0, 5, d);
        total++;
        if (d !== 32'h0) $display("FAIL offset5_read got %h want 0", d);
        else passed++;
        wr(1, 4, 32'h0001_0000);
        rd(1, 4, d);
        total++;
        if (d !== model_status(1)) $display("FAIL status_ro got %h want %h", d, model_status(1));
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [2:0]  e1, e2;
        int c1, r1, b1, c2, r2, b2;
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(1, 5)) begin
                int reg_i, off;
                logic [31:0] v;
                reg_i = $urandom_range(0, 3);
                off = $urandom_range(0, 7);
                v = $urandom;
                if (off == 0)
                    v = {8'($urandom_range(0, 40)), 8'($urandom_range(0, 63)),
                         8'($urandom_range(0, 10)), 8'($urandom_range(0, 15))};
                wr(reg_i, off, v);
            end
            event_trigger = NR'($urandom);
            c1 = $urandom_range(0, 63); r1 = $urandom_range(0, 15); b1 = $urandom_range(0, 9);
            c2 = $urandom_range(0, 63); r2 = $urandom_range(0, 15); b2 = $urandom_range(0, 9);
            px(c1, r1, b1, c2, r2, b2);
            e1 = model_px(c1, r1, b1); e2 = model_px(c2, r2, b2);
            total++;
            if ({blue1, green1, red1, blue2, green2, red2} !== {e1, e2})
                $display("FAIL rand_mid_px it%0d got %b want %b", it, {blue1, green1, red1, blue2, green2, red2}, {e1, e2});
            else passed++;
            frame();
            for (int i = 0; i < NR; i++) begin
                rd(i, 4, d);
                total++;
                if (d !== model_status(i)) $display("FAIL rand_status it%0d r%0d got %h want %h", it, i, d, model_status(i));
                else passed++;
            end
            repeat (2) begin
                c1 = $urandom_range(0, 63); r1 = $urandom_range(0, 15); b1 = $urandom_range(0, 9);
                c2 = $urandom_range(0, 63); r2 = $urandom_range(0, 15); b2 = $urandom_range(0, 9);
                px(c1, r1, b1, c2, r2, b2);
                e1 = model_px(c1, r1, b1); e2 = model_px(c2, r2, b2);
                total++;
                if ({blue1, green1, red1, blue2, green2, red2} !== {e1, e2})
                    $display("FAIL rand_px it%0d got %b want %b", it, {blue1, green1, red1, blue2, green2, red2}, {e1, e2});
                else passed++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_dim();
        test_step();
        test_pulse();
        test_reset_mid_pulse();
        test_overlap_shadow();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multi_region_animator.md
Name: multi_region_animator

Overview:
- Parametrised successor to the single-region step animation block.
- Drives NUM_REGIONS independent rectangular regions, each with its own colour, mode and per-frame brightness envelope: step, dim ramp, or pulsing.
- Sits between the panel scanner (col/row/bitplane pixel query, two half-panel channels) and the Avalon-MM register bus.
- Brightness advances once per v_sync rising edge; per-region colours are pre-scaled once per frame so the pixel path stays multiplier-free.

Parameters:
- NUM_REGIONS, 4, number of independent regions (1..16).
- ROW_BITS, 4, pixel row coordinate width.
- COL_BITS, 6, pixel column coordinate width.
- COLOR_BITS, 8, bits per colour channel (max 16).
- LEVEL_BITS, 8, brightness level width; LMAX = 2^LEVEL_BITS-1.

Ports:
- clock_clk  in  1  single system clock.
- reset_rst  in  1  asynchronous, active-high reset.
- v_sync  in  1  frame sync, asynchronous to clock_clk.
- s0_address  in  $clog2(NUM_REGIONS)+3  {region index, register offset[2:0]}.
- s0_read  in  1  read strobe.
- s0_readdata  out  32  registered read data.
- s0_write  in  1  write strobe.
- s0_writedata  in  32  write data.
- event_trigger  in  NUM_REGIONS  per-region trigger; assumed synchronous to clock_clk.
- col1 / col2  in  COL_BITS  pixel column, channel 1/2.
- row1 / row2  in  ROW_BITS  pixel row, channel 1/2.
- bitplane1 / bitplane2  in  4  colour bit index, channel 1/2.
- red1/green1/blue1  out  1 each  channel-1 pixel bits.
- red2/green2/blue2  out  1 each  channel-2 pixel bits.

Behaviour:
- Reset (async): all registers, levels, shadows, scaled colours, s0_readdata and all pixel outputs go to 0; mode=OFF; scaler FSM to IDLE.
- Registers per region, by offset:
  - 0: bounds {startcol[31:24], endcol[23:16], startrow[15:8], endrow[7:0]}.
  - 1: colour {B[23:16], G[15:8], R[7:0]}, truncated to COLOR_BITS.
  - 2: mode[1:0]: 0 OFF, 1 STEP, 2 DIM, 3 PULSE.
  - 3: step[LEVEL_BITS-1:0]; 0 freezes the level.
  - 4: status, read-only {dir[16], level[LEVEL_BITS-1:0]}.
  - Writes to offset 4 or 5..7, or to a region index >= NUM_REGIONS, are ignored. Reads of those return 0.
- Read latency: exactly 1 cycle. s0_readdata is 0 in any cycle following no read.
- v_sync is passed through a 2-FF synchroniser and then an edge detector. tick = one-cycle pulse on the synchronised rising edge.
- On tick, per region (sub-module), saturating arithmetic, computed in LEVEL_BITS+1 bits:
  - OFF: level <= 0.
  - STEP: level <= trig ? LMAX : 0.
  - DIM: trig ? min(level+step, LMAX) : max(level-step, 0).
  - PULSE, trig=1: dir=up adds step; on reaching or clipping at LMAX, level=LMAX and dir<=down. Down subtracts; on reaching or clipping at 0, dir<=up.
  - PULSE, trig=0: ramp down toward 0 and force dir<=up.
- Also on tick: bounds and colour are copied into shadow registers. Mid-frame register writes do not affect pixels until the next tick.
- Scaler FSM:
  - IDLE -> SCALE on the cycle after tick.
  - SCALE handles one region per cycle, index 0..NUM_REGIONS-1.
  - Per channel, scaled = (level==LMAX) ? colour : (colour*level)>>LEVEL_BITS.
  - SCALE -> IDLE after the last region.
  - A tick arriving during SCALE is ignored by the FSM, but levels still update.
- Pixel path, computed per channel:
  - Hit = startcol<=col<=endcol and startrow<=row<=endrow (shadow values).
  - A region with start > end never hits.
  - The lowest-index hit region wins.
  - Output bit = scaled_colour[bitplane]. It is 0 when there is no hit or when bitplane >= COLOR_BITS.
  - Latency is 1 cycle, registered. The two channels are independent.
- Event trigger is sampled only on tick. Pulses shorter than a frame are missed by design.

Decomposition:
- Package anim_pkg:
  - Mode encodings MODE_OFF/STEP/DIM/PULSE.
  - Register offsets REG_BOUNDS, REG_COLOR, REG_MODE, REG_STEP, REG_STATUS.
  - Field bit positions.
- Sub-module anim_level_ctrl:
  - Holds one region's level/dir state and saturating update logic.
  - Instantiated NUM_REGIONS times.
  - Inputs: tick, trig, mode, step. Outputs: level, dir.
- Top contains the register file, the synchroniser, the scaler FSM and the two pixel lookup paths.

Test Plan:
- Reset, then read every address -> 0. Assert reset mid-PULSE -> level, dir and pixel outputs go to 0 immediately.
- Region0: bounds 0x0A140208, colour 0x0000FF, mode DIM, step 64, trig0=1. After 4 ticks, level reads 64/128/192/255 (saturates). Pixel (col 10, row 2, bitplane 7) gives red1=1. Drop trig: after 4 ticks level is 0 and red1=0.
- STEP mode, colour R=0x80, trig=1 -> next tick level=LMAX. bitplane 7 gives 1, bitplane 6 gives 0, bitplane 9 gives 0.
- PULSE, step 100, trig held -> levels 100, 200, 255 (dir down), 155, 55, 0 (dir up), 100.
- Overlap: regions 0 and 1 both cover (5,5) with colours R=0xFF and G=0xFF, both STEP and triggered -> red=1, green=0. Disable region 0 -> green=1.
- Write new bounds mid-frame -> pixel outputs unchanged until the next v_sync rising edge. Pixel with start>end never lights. Write to region index >= NUM_REGIONS -> ignored.
